countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  BCD countdown game timer: counts a loaded 2-digit seconds value down to 00 at 1 tick per
//  CLOCK_FREQUENCY cycles. Supports start, pause/resume and reload.
//  Drives HEX4/HEX5 digits through hex_decoder, and the game FSM via Done/Expired/Warning.
//  It is the down-counting counterpart of the elapsed-time counter.
// PARAMETERS
//  CLOCK_FREQUENCY  50000000  ClockIn cycles per one-second tick (>=2)
//  START_TENS       9         tens digit loaded at reset (0-9)
//  START_ONES       9         ones digit loaded at reset (0-9)
//  WARN_SECONDS     10        Warning asserts when remaining <= this value (binary, 1-99)
// PORTS
//  ClockIn       in   1  system clock, all logic on rising edge
//  Resetn        in   1  synchronous active-low reset
//  Load          in   1  load LoadTens/LoadOnes, go to IDLE
//  LoadTens      in   4  BCD tens for Load
//  LoadOnes      in   4  BCD ones for Load
//  Start         in   1  start from IDLE / resume from PAUSED
//  Pause         in   1  freeze countdown while in RUN
//  TensValue     out  4  current tens digit (BCD)
//  OnesValue     out  4  current ones digit (BCD)
//  RemainingBin  out  7  TensValue*10+OnesValue, binary 0-99
//  Running       out  1  state==RUN
//  Warning       out  1  (RUN or PAUSED) && 0<RemainingBin<=WARN_SECONDS
//  Expired       out  1  one-cycle pulse on entry to DONE
//  Done          out  1  state==DONE, level
// BEHAVIOUR
//  - States: IDLE, RUN, PAUSED, DONE. All outputs are registers or decodes of registers, with
//    no combinational path from inputs.
//  - Reset (Resetn=0 at an edge): state=IDLE; digits=START_TENS/START_ONES; prescaler=
//    CLOCK_FREQUENCY-1; Expired=0. Outputs therefore reset to Running=0, Done=0, Warning=0.
//  - Input priority each cycle: Resetn > Load > Pause > Start.
//  - Load (any state): any digit >9 is clamped to 9; the clamped digits are stored;
//    state=IDLE; prescaler reloaded; Done clears next cycle.
//  - IDLE: Start with value!=00 -> RUN, prescaler=CLOCK_FREQUENCY-1.
//    Start with value==00 -> DONE, Expired pulses.
//  - RUN: prescaler decrements each cycle. When prescaler==0: reload, and the digits
//    decrement one second. Digits update exactly CLOCK_FREQUENCY cycles after RUN entry.
//  - Decrement rule: ones>0 -> ones-1. ones==0 -> ones=9, tens-1.
//  - Tick taking the value 01->00: state=DONE and Expired=1 in the same cycle the digits read 00.
//    Expired clears the following cycle.
//  - RUN + Pause -> PAUSED. The prescaler is held, not reloaded, so the partial second is kept.
//    Pause on the same cycle as prescaler==0 wins: no tick, prescaler held at 0, and the tick
//    fires on the first RUN cycle after resume.
//  - PAUSED + Start -> RUN, resuming the prescaler from its held value. Pause in PAUSED is a
//    no-op.
//  - DONE: digits held at 00, no underflow ever. Start and Pause are ignored. Exit only via
//    Load or reset.
//  - Reset or Load mid-RUN aborts the countdown immediately. No Expired pulse is produced.
//  - Simultaneous Start+Pause: Pause wins. In IDLE the pair is a no-op (stay in IDLE).
//  - Prescaler width: $clog2(CLOCK_FREQUENCY).
// TESTING (bench uses CLOCK_FREQUENCY=4, WARN_SECONDS=10)
//  1. Resetn=0 for 2 cycles -> Tens=9, Ones=9, RemainingBin=99, Running=0, Done=0, Expired=0.
//  2. Load 1/2, Start -> value 11 after 4 RUN cycles. Value 00 after 48 RUN cycles, with
//     Expired high exactly 1 cycle, Done=1 and Running=0 held.
//  3. Load 2/0, Start, run 4 cycles -> borrow gives Tens=1, Ones=9, RemainingBin=19.
//  4. Start, 2 RUN cycles, Pause for 5 cycles, Start -> next tick exactly 2 RUN cycles after
//     resume. No tick occurs while PAUSED.
//  5. Load 0/0 + Start -> DONE next cycle, with an Expired pulse and digits 00.
//     Load F/C -> clamped to 99.
//  6. Load 1/1, Start -> Warning=0 at 11, Warning=1 at 10, Warning=0 at 00.
//     Load or Resetn=0 mid-RUN -> IDLE with the new value and no Expired pulse.

Source files
------------

// File: rtl/countdown_timer.sv
// BCD two-digit countdown game timer.
// One-second prescaler, pause/resume, reload and expiry pulse.
module countdown_timer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int START_TENS      = 9,
    parameter int START_ONES      = 9,
    parameter int WARN_SECONDS    = 10
) (
    input  logic       ClockIn,
    input  logic       Resetn,
    input  logic       Load,
    input  logic [3:0] LoadTens,
    input  logic [3:0] LoadOnes,
    input  logic       Start,
    input  logic       Pause,
    output logic [3:0] TensValue,
    output logic [3:0] OnesValue,
    output logic [6:0] RemainingBin,
    output logic       Running,
    output logic       Warning,
    output logic       Expired,
    output logic       Done
);

    localparam int PW = $clog2(CLOCK_FREQUENCY);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCK_FREQUENCY - 1);
    localparam logic [6:0] WARN_B = 7'(WARN_SECONDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_tens;
    logic [3:0]    w_tens_nxt;
    logic [3:0]    r_ones;
    logic [3:0]    w_ones_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          r_expired;
    logic          w_expired_nxt;
    logic [3:0]    w_ld_tens;
    logic [3:0]    w_ld_ones;
    logic          w_is_zero;
    logic          w_is_one;

    assign w_ld_tens = (LoadTens > 4'd9) ? 4'd9 : LoadTens;
    assign w_ld_ones = (LoadOnes > 4'd9) ? 4'd9 : LoadOnes;
    assign w_is_zero = (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_is_one  = (r_tens == 4'd0) && (r_ones == 4'd1);

    // State, digit, prescaler and expiry-pulse registers
    always_ff @(posedge ClockIn) begin
        if (!Resetn) begin
            r_state   <= S_IDLE;
            r_tens    <= 4'(START_TENS);
            r_ones    <= 4'(START_ONES);
            r_presc   <= PRESC_MAX;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tens    <= w_tens_nxt;
            r_ones    <= w_ones_nxt;
            r_presc   <= w_presc_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    // Next state: Load beats Pause beats Start; a paused prescaler keeps its count
    always_comb begin
        w_state_nxt   = r_state;
        w_tens_nxt    = r_tens;
        w_ones_nxt    = r_ones;
        w_presc_nxt   = r_presc;
        w_expired_nxt = 1'b0;
        if (Load) begin
            w_state_nxt = S_IDLE;
            w_tens_nxt  = w_ld_tens;
            w_ones_nxt  = w_ld_ones;
            w_presc_nxt = PRESC_MAX;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!Pause && Start) begin
                        if (w_is_zero) begin
                            w_state_nxt   = S_DONE;
                            w_expired_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_RUN;
                            w_presc_nxt = PRESC_MAX;
                        end
                    end
                end
                S_RUN: begin
                    if (Pause) begin
                        w_state_nxt = S_PAUSED;
                    end else if (r_presc == '0) begin
                        w_presc_nxt = PRESC_MAX;
                        if (r_ones != 4'd0) begin
                            w_ones_nxt = r_ones - 4'd1;
                        end else begin
                            w_ones_nxt = 4'd9;
                            w_tens_nxt = r_tens - 4'd1;
                        end
                        if (w_is_one) begin
                            w_state_nxt   = S_DONE;
                            w_expired_nxt = 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc - PW'(1);
                    end
                end
                S_PAUSED: begin
                    if (!Pause && Start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Output decodes of the registered state
    always_comb begin
        TensValue    = r_tens;
        OnesValue    = r_ones;
        RemainingBin = ({3'b000, r_tens} * 7'd10) + {3'b000, r_ones};
        Running      = (r_state == S_RUN);
        Done         = (r_state == S_DONE);
        Expired      = r_expired;
        Warning      = ((r_state == S_RUN) || (r_state == S_PAUSED))
                       && (RemainingBin != 7'd0)
                       && (RemainingBin <= WARN_B);
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer.
// Second-granular reference model plus directed boundary checks.
module tb_countdown_timer;

    localparam int CF   = 4;
    localparam int WARN = 10;

    logic       clk;
    logic       Resetn;
    logic       Load;
    logic [3:0] LoadTens;
    logic [3:0] LoadOnes;
    logic       Start;
    logic       Pause;
    logic [3:0] TensValue;
    logic [3:0] OnesValue;
    logic [6:0] RemainingBin;
    logic       Running;
    logic       Warning;
    logic       Expired;
    logic       Done;

    countdown_timer #(
        .CLOCK_FREQUENCY(CF),
        .START_TENS(9),
        .START_ONES(9),
        .WARN_SECONDS(WARN)
    ) dut (
        .ClockIn(clk),
        .Resetn(Resetn),
        .Load(Load),
        .LoadTens(LoadTens),
        .LoadOnes(LoadOnes),
        .Start(Start),
        .Pause(Pause),
        .TensValue(TensValue),
        .OnesValue(OnesValue),
        .RemainingBin(RemainingBin),
        .Running(Running),
        .Warning(Warning),
        .Expired(Expired),
        .Done(Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: seconds left, cycles elapsed in the current second
    int m_rem   = 99;
    int m_phase = 0;
    int m_st    = 0;
    bit m_exp   = 1'b0;

    logic [18:0] q[$];

    function automatic int clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic logic [18:0] enc(input int rem, input int st,
                                        input bit ex);
        logic [3:0] t;
        logic [3:0] o;
        logic [6:0] r;
        logic       w;
        t = 4'(rem / 10);
        o = 4'(rem % 10);
        r = 7'(rem);
        w = (st == 1 || st == 2) && rem > 0 && rem <= WARN;
        return {t, o, r, (st == 1), w, ex, (st == 3)};
    endfunction

    task automatic model_step(input bit rn, input bit ld,
                              input logic [3:0] lt, input logic [3:0] lo,
                              input bit st, input bit pa);
        m_exp = 1'b0;
        if (!rn) begin
            m_st = 0; m_rem = 99; m_phase = 0;
        end else if (ld) begin
            m_st = 0; m_rem = clamp9(lt) * 10 + clamp9(lo); m_phase = 0;
        end else begin
            case (m_st)
                0: if (!pa && st) begin
                    if (m_rem == 0) begin m_st = 3; m_exp = 1'b1; end
                    else begin m_st = 1; m_phase = 0; end
                end
                1: if (pa) begin
                    m_st = 2;
                end else if (m_phase == CF - 1) begin
                    m_phase = 0;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin m_st = 3; m_exp = 1'b1; end
                end else begin
                    m_phase = m_phase + 1;
                end
                2: if (!pa && st) m_st = 1;
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit rn, input bit ld, input logic [3:0] lt,
                       input logic [3:0] lo, input bit st, input bit pa);
        @(negedge clk);
        Resetn = rn; Load = ld; LoadTens = lt; LoadOnes = lo;
        Start = st; Pause = pa;
        model_step(rn, ld, lt, lo, st, pa);
        q.push_back(enc(m_rem, m_st, m_exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 4'd0, 4'd0, 0, 0);
    endtask

    task automatic settle;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    // monitor: compare every registered output against the queued model
    always @(posedge clk) begin
        logic [18:0] e;
        logic [18:0] a;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {TensValue, OnesValue, RemainingBin,
                 Running, Warning, Expired, Done};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got T%0d O%0d R%0d run%b warn%b exp%b done%b required T%0d O%0d R%0d run%b warn%b exp%b done%b",
                         $time, a[18:15], a[14:11], a[10:4], a[3], a[2], a[1], a[0],
                         e[18:15], e[14:11], e[10:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        Resetn = 0; Load = 0; LoadTens = 0; LoadOnes = 0;
        Start = 0; Pause = 0;

        cyc(0, 0, 4'd0, 4'd0, 0, 0);
        cyc(0, 0, 4'd0, 4'd0, 0, 0);
        settle();
        chk("reset_tens", int'(TensValue), 9);
        chk("reset_ones", int'(OnesValue), 9);
        chk("reset_rem", int'(RemainingBin), 99);
        chk("reset_run_done_exp", int'({Running, Done, Expired}), 0);

        cyc(1, 1, 4'd1, 4'd2, 0, 0);
        cyc(1, 0, 4'd0, 4'd0, 1, 0);
        idle(4);
        settle();
        chk("first_tick_11", int'(RemainingBin), 11);
        idle(44);
        settle();
        chk("expire_rem0", int'(RemainingBin), 0);
        chk("expire_pulse", int'(Expired), 1);
        chk("expire_done_run", int'({Done, Running}), 2);
        idle(3);
        settle();
        chk("done_held_exp_low", int'({Done, Expired, RemainingBin}), 256);

        cyc(1, 1, 4'd2, 4'd0, 0, 0);
        cyc(1, 0, 4'd0, 4'd0, 1, 0);
        idle(4);
        settle();
        chk("borrow_tens", int'(TensValue), 1);
        chk("borrow_ones", int'(OnesValue), 9);

        cyc(1, 1, 4'd3, 4'd0, 0, 0);
        cyc(1, 0, 4'd0, 4'd0, 1, 0);
        idle(2);
        for (int i = 0; i < 5; i++) cyc(1, 0, 4'd0, 4'd0, 0, 1);
        settle();
        chk("paused_no_tick", int'(RemainingBin), 30);
        cyc(1, 0, 4'd0, 4'd0, 1, 0);
        idle(1);
        settle();
        chk("resume_before_tick", int'(RemainingBin), 30);
        idle(1);
        settle();
        chk("resume_tick", int'(RemainingBin), 29);

        cyc(1, 1, 4'd0, 4'd0, 0, 0);
        cyc(1, 0, 4'd0, 4'd0, 1, 0);
        settle();
        chk("zero_start_done", int'({Done, Expired}), 3);
        cyc(1, 1, 4'hF, 4'hC, 0, 0);
        settle();
        chk("clamp_99", int'(RemainingBin), 99);
        chk("load_clears_done", int'(Done), 0);

        cyc(1, 1, 4'd1, 4'd1, 0, 0);
        cyc(1, 0, 4'd0, 4'd0, 1, 0);
        idle(4);
        settle();
        chk("warn_at_10", int'(Warning), 1);
        cyc(1, 1, 4'd4, 4'd2, 1, 1);
        settle();
        chk("load_abort_rem", int'(RemainingBin), 42);
        chk("load_abort_flags", int'({Running, Done, Expired}), 0);
        cyc(1, 0, 4'd0, 4'd0, 1, 1);
        cyc(1, 0, 4'd0, 4'd0, 1, 0);
        idle(2);
        cyc(0, 1, 4'd1, 4'd1, 1, 0);
        settle();
        chk("reset_abort_rem", int'(RemainingBin), 99);
        chk("reset_abort_run", int'(Running), 0);

        for (int i = 0; i < 4000; i++) begin
            bit rn;
            bit ld;
            logic [3:0] lt;
            logic [3:0] lo;
            rn = ($urandom_range(0, 499) != 0);
            ld = ($urandom_range(0, 249) == 0);
            lt = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(0, 1));
            lo = 4'($urandom_range(0, 15));
            cyc(rn, ld, lt, lo, ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 9) == 0));
        end
        idle(2);
        settle();
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
